// File: rtl/alu_muldiv_control.sv
// MIPS ALU control decode plus an iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Optional MTHI/MTLO support is compiled in when MTHILO_EN is defined.
module alu_muldiv_control #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ALU_CTRL_W = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [1:0]            alu_op_i,
    input  logic [5:0]            funct_i,
    input  logic                  instr_valid_i,
    input  logic [WIDTH-1:0]      rs_val_i,
    input  logic [WIDTH-1:0]      rt_val_i,
    output logic [ALU_CTRL_W-1:0] alu_ctrl_o,
    output logic                  jr_ctrl_o,
    output logic                  stall_o,
    output logic                  done_o,
    output logic [WIDTH-1:0]      hi_o,
    output logic [WIDTH-1:0]      lo_o
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StIter, StFix, StDone} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [WIDTH-1:0]  hi_q, lo_q;
    logic              done_q;
    logic [WIDTH-1:0]  acc_q;      // partial product high half / partial remainder
    logic [WIDTH-1:0]  mq_q;       // multiplier / dividend-then-quotient
    logic [WIDTH-1:0]  b_q;        // multiplicand / divisor magnitude
    logic              is_div_q;
    logic              res_neg_q;  // product or quotient needs negation
    logic              rem_neg_q;

    logic [3:0]        ctrl4;
    logic              rtype, muldiv_req, mf_req, hold_req;
    logic              op_signed, op_div, a_neg, b_neg, div_zero;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [WIDTH:0]    mul_sum, div_shift;
    logic              div_ge;
    logic [WIDTH-1:0]  div_rem;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]  hi_d, lo_d;

    // ALU control decode
    always_comb begin
        ctrl4 = 4'b0010;
        case (alu_op_i)
            2'b00: ctrl4 = 4'b0010;
            2'b01: ctrl4 = 4'b0110;
            2'b10: begin
                case (funct_i)
                    6'b100000: ctrl4 = 4'b0010;
                    6'b100010: ctrl4 = 4'b0110;
                    6'b100100: ctrl4 = 4'b0000;
                    6'b100101: ctrl4 = 4'b0001;
                    6'b100110: ctrl4 = 4'b0011;
                    6'b100111: ctrl4 = 4'b1100;
                    6'b101010: ctrl4 = 4'b0111;
                    6'b101011: ctrl4 = 4'b1000;
                    default:   ctrl4 = 4'b0010;
                endcase
            end
            default: ctrl4 = 4'b0010;
        endcase
    end

    assign alu_ctrl_o = ALU_CTRL_W'(ctrl4);
    assign rtype      = (alu_op_i == 2'b10);
    assign jr_ctrl_o  = rtype && (funct_i == 6'b001000);
    assign muldiv_req = instr_valid_i && rtype && (funct_i[5:2] == 4'b0110);
    assign mf_req     = instr_valid_i && rtype &&
                        ((funct_i == 6'b010000) || (funct_i == 6'b010010));

`ifdef MTHILO_EN
    logic mt_req;
    assign mt_req   = instr_valid_i && rtype &&
                      ((funct_i == 6'b010001) || (funct_i == 6'b010011));
    assign hold_req = mf_req || mt_req;
`else
    assign hold_req = mf_req;
`endif

    assign stall_o = (state_q == StIter) || (state_q == StFix) ||
                     ((state_q == StIdle) && muldiv_req) ||
                     ((state_q != StIdle) && hold_req);

    // Operand preparation: funct[0]=1 selects unsigned, funct[1]=1 selects divide
    always_comb begin
        op_signed = ~funct_i[0];
        op_div    = funct_i[1];
        a_neg     = op_signed && rs_val_i[WIDTH-1];
        b_neg     = op_signed && rt_val_i[WIDTH-1];
        a_mag     = a_neg ? -rs_val_i : rs_val_i;
        b_mag     = b_neg ? -rt_val_i : rt_val_i;
        div_zero  = op_div && (rt_val_i == '0);
    end

    // One iteration step for each operation
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, b_q} : '0);
        div_shift = {acc_q, mq_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_q});
        div_rem   = div_shift[WIDTH-1:0] - b_q;
    end

    // Sign correction applied in StFix
    always_comb begin
        prod     = {acc_q, mq_q};
        prod_fix = res_neg_q ? -prod : prod;
        if (is_div_q) begin
            lo_d = res_neg_q ? -mq_q : mq_q;
            hi_d = rem_neg_q ? -acc_q : acc_q;
        end else begin
            lo_d = prod_fix[WIDTH-1:0];
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            acc_q     <= '0;
            mq_q      <= '0;
            b_q       <= '0;
            is_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (muldiv_req) begin
                        state_q  <= StIter;
                        cnt_q    <= CntW'(WIDTH - 1);
                        acc_q    <= '0;
                        b_q      <= b_mag;
                        is_div_q <= op_div;
                        // Zero divisor: raw dividend falls out as remainder, quotient all ones
                        if (div_zero) begin
                            mq_q      <= rs_val_i;
                            res_neg_q <= 1'b0;
                            rem_neg_q <= 1'b0;
                        end else begin
                            mq_q      <= a_mag;
                            res_neg_q <= a_neg ^ b_neg;
                            rem_neg_q <= a_neg;
                        end
                    end
`ifdef MTHILO_EN
                    else if (mt_req) begin
                        if (funct_i[1]) lo_q <= rs_val_i;
                        else            hi_q <= rs_val_i;
                    end
`endif
                end
                StIter: begin
                    if (is_div_q) begin
                        acc_q <= div_ge ? div_rem : div_shift[WIDTH-1:0];
                        mq_q  <= {mq_q[WIDTH-2:0], div_ge};
                    end else begin
                        acc_q <= mul_sum[WIDTH:1];
                        mq_q  <= {mul_sum[0], mq_q[WIDTH-1:1]};
                    end
                    if (cnt_q == '0) state_q <= StFix;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                StFix: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    done_q  <= 1'b1;
                    state_q <= StDone;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_alu_muldiv_control.sv
// Scoreboard bench for alu_muldiv_control: decode sweep, mul/div results, stall and reset.
module tb_alu_muldiv_control;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    alu_op;
    logic [5:0]    funct;
    logic          instr_valid;
    logic [W-1:0]  rs_val, rt_val;
    logic [3:0]    alu_ctrl;
    logic          jr_ctrl, stall, done;
    logic [W-1:0]  hi, lo;

    int errors = 0;
    int checks = 0;
    logic [2*W-1:0] sb_q[$];

    typedef struct packed {
        logic [1:0] op;
        logic [5:0] f;
        logic [3:0] ctrl;
        logic       jr;
    } dec_t;

    alu_muldiv_control #(.WIDTH(W), .ALU_CTRL_W(4)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .alu_op_i     (alu_op),
        .funct_i      (funct),
        .instr_valid_i(instr_valid),
        .rs_val_i     (rs_val),
        .rt_val_i     (rt_val),
        .alu_ctrl_o   (alu_ctrl),
        .jr_ctrl_o    (jr_ctrl),
        .stall_o      (stall),
        .done_o       (done),
        .hi_o         (hi),
        .lo_o         (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected HI/LO pair
    always @(negedge clk) begin
        if (rst_n && done) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got hi=%h lo=%h, expected no done", hi, lo);
            end else begin
                logic [2*W-1:0] e;
                e = sb_q.pop_front();
                if ({hi, lo} !== e) begin
                    errors++;
                    $display("FAIL hilo: got %h_%h, expected %h_%h", hi, lo, e[2*W-1:W], e[W-1:0]);
                end
            end
        end
    end

    // Issue one mul/div, checking stall and done timing; optional MFLO at cycle mf_at
    task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo, input int mf_at);
        logic exp_stall;
        @(negedge clk);
        alu_op = 2'b10; funct = f; rs_val = a; rt_val = b; instr_valid = 1'b1;
        sb_q.push_back({ehi, elo});
        #1 chk("stall_cycle0", {63'd0, stall}, 64'd1);
        for (int k = 1; k <= W + 2; k++) begin
            @(negedge clk);
            if (mf_at != 0 && k == mf_at) funct = 6'b010010;
            #1;
            exp_stall = (k <= W + 1) || (mf_at != 0 && k >= mf_at);
            if (stall !== exp_stall) chk($sformatf("stall_c%0d", k), {63'd0, stall},
                                         {63'd0, exp_stall});
            if (done !== (k == W + 2)) chk($sformatf("done_c%0d", k), {63'd0, done},
                                           {63'd0, (k == W + 2)});
        end
        checks++;
        if (mf_at != 0) begin
            @(negedge clk);
            #1;
            chk("mflo_stall_idle", {63'd0, stall}, 64'd0);
            chk("mflo_lo", {32'd0, lo}, {32'd0, elo});
        end
        instr_valid = 1'b0;
    endtask

    initial begin
        dec_t tbl[14];
        tbl = '{
            '{2'b10, 6'b100000, 4'b0010, 1'b0}, '{2'b10, 6'b100010, 4'b0110, 1'b0},
            '{2'b10, 6'b100100, 4'b0000, 1'b0}, '{2'b10, 6'b100101, 4'b0001, 1'b0},
            '{2'b10, 6'b100110, 4'b0011, 1'b0}, '{2'b10, 6'b100111, 4'b1100, 1'b0},
            '{2'b10, 6'b101010, 4'b0111, 1'b0}, '{2'b10, 6'b101011, 4'b1000, 1'b0},
            '{2'b00, 6'b100010, 4'b0010, 1'b0}, '{2'b01, 6'b100000, 4'b0110, 1'b0},
            '{2'b10, 6'b001000, 4'b0010, 1'b1}, '{2'b00, 6'b001000, 4'b0010, 1'b0},
            '{2'b10, 6'b111111, 4'b0010, 1'b0}, '{2'b10, 6'b010001, 4'b0010, 1'b0}
        };
        rst_n = 1'b0; alu_op = 2'b00; funct = 6'd0; instr_valid = 1'b0;
        rs_val = '0; rt_val = '0;
        #12;
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        @(negedge clk) rst_n = 1'b1;

        foreach (tbl[i]) begin
            alu_op = tbl[i].op; funct = tbl[i].f;
            #1;
            chk($sformatf("alu_ctrl_%0d", i), {60'd0, alu_ctrl}, {60'd0, tbl[i].ctrl});
            chk($sformatf("jr_ctrl_%0d", i), {63'd0, jr_ctrl}, {63'd0, tbl[i].jr});
        end

        run_op(6'b011000, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 0);
        run_op(6'b011001, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 0);
        run_op(6'b011010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run_op(6'b011011, 32'h80000000, 32'h00000000, 32'h80000000, 32'hFFFFFFFF, 0);
        run_op(6'b011010, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 0);
        run_op(6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);
        run_op(6'b011011, 32'd100, 32'd7, 32'd2, 32'd14, 0);
        run_op(6'b011010, 32'd35, 32'd5, 32'd0, 32'd7, 5);

        // Abort a MULT at cycle 10 with HI/LO holding the previous result
        @(negedge clk);
        alu_op = 2'b10; funct = 6'b011000; rs_val = 32'd7; rt_val = 32'd9; instr_valid = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b0; instr_valid = 1'b0;
        #1;
        chk("abort_hi", {32'd0, hi}, 64'd0);
        chk("abort_lo", {32'd0, lo}, 64'd0);
        chk("abort_stall", {63'd0, stall}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (40) @(negedge clk);
        run_op(6'b011000, 32'd5, 32'd6, 32'd0, 32'd30, 0);

        // MTHI only acts when the option is compiled in
        @(negedge clk);
        alu_op = 2'b10; funct = 6'b010001; rs_val = 32'h1234; instr_valid = 1'b1;
        #1 chk("mthi_stall", {63'd0, stall}, 64'd0);
        @(negedge clk) instr_valid = 1'b0;
        #1;
`ifdef MTHILO_EN
        chk("mthi_hi", {32'd0, hi}, 64'h1234);
`else
        chk("mthi_hi", {32'd0, hi}, 64'd0);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_muldiv_control.md
Name: alu_muldiv_control

Overview:
- Next-generation ALU control for the MIPS datapath.
- Decodes ALUOp/funct into the ALU control code and the JR flag, as the current decoder does. The decode table is extended with XOR, NOR and SLTU.
- Adds an iterative sequencer for MULT/MULTU/DIV/DIVU that owns the HI/LO registers.
- Provides a stall output that holds the fetch stage while a multiply or divide is in flight, or while an MFHI/MFLO read would return stale data.

Parameters:
- WIDTH, 32, operand/HI/LO width in bits (>=4).
- ALU_CTRL_W, 4, width of the ALU control code.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- alu_op  in  2  from main control: 00 mem, 01 branch, 10 R-type.
- funct  in  6  instruction funct field.
- instr_valid  in  1  current instruction is valid (not bubble).
- rs_val  in  WIDTH  operand A / dividend.
- rt_val  in  WIDTH  operand B / divisor.
- alu_ctrl  out  ALU_CTRL_W  ALU control code (combinational).
- jr_ctrl  out  1  JR select (combinational).
- stall  out  1  hold PC/IF (combinational).
- done  out  1  one-cycle pulse: HI/LO just updated.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Combinational decode of alu_ctrl (zero-extended to ALU_CTRL_W):
  - alu_op 00 -> 0010.
  - alu_op 01 -> 0110.
  - alu_op 10 with funct: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 100110 -> 0011, 100111 -> 1100, 101010 -> 0111, 101011 -> 1000.
  - Anything else -> 0010.
- jr_ctrl = (alu_op==10 && funct==001000).
- muldiv_req = instr_valid && alu_op==10 && funct in {011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU}.
- States: IDLE, ITER, FIX, DONE.
  - IDLE: on muldiv_req, latch operand magnitudes, result sign flags and op type; go to ITER with counter = WIDTH-1.
  - ITER: one shift-add (mul) or restoring subtract-shift (div) step per cycle, operating on unsigned magnitudes. The counter decrements; when it reaches 0, go to FIX. ITER lasts exactly WIDTH cycles.
  - FIX: apply two's-complement sign correction; write hi/lo at the end of this cycle; go to DONE.
  - DONE: done=1 for exactly this cycle; go to IDLE.
- Latency: with the start edge as cycle 0, hi/lo are valid and done=1 at cycle WIDTH+2.
- Results:
  - mul: {hi,lo} = full 2*WIDTH-bit product.
  - div: lo = quotient truncated toward zero; hi = remainder, sign of dividend.
- Divide by zero (signed or unsigned): hi = rs_val, lo = all ones; same latency; no sign correction.
- Signed most-negative / -1: lo = most-negative value, hi = 0.
- stall = (state in {ITER, FIX}) || (state==IDLE && muldiv_req) || (state != IDLE && instr_valid && alu_op==10 && funct in {010000 MFHI, 010010 MFLO}).
  - stall is low in DONE unless an MFHI/MFLO is present.
- Re-trigger: the sequencer starts only from IDLE. A muldiv_req in ITER/FIX/DONE is ignored. The held instruction re-requests after DONE, so the pipeline must clear instr_valid, or advance past the instruction, on done.
- Reset (any time, including mid-operation): state=IDLE, counter=0, hi=0, lo=0, done=0; stall then follows its combinational definition. An in-flight operation is discarded with no partial HI/LO update.

Optional Feature:
- Macro MTHILO_EN.
- Defined: funct 010001 (MTHI) / 010011 (MTLO) with alu_op==10 && instr_valid in IDLE writes rs_val into hi / lo at the next edge. No stall, no done pulse. If issued while not IDLE, they stall until IDLE.
- Undefined: both functs decode as default (alu_ctrl 0010) and have no effect on HI/LO or stall.

Test Plan (WIDTH=32):
- Decode sweep: alu_op=10 over all listed functs, plus alu_op 00/01, plus funct=001000 -> alu_ctrl values per table, jr_ctrl=1 only for 10/001000, default 0010 for an unlisted funct.
- MULT rs=0xFFFFFFFE (-2), rt=0x00000003 -> after 34 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFA, done one-cycle pulse, stall high cycles 0..33.
- MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=-7, rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU rs=0x80000000, rt=0 -> hi=0x80000000, lo=0xFFFFFFFF.
- Issue MFLO at cycle 5 of a DIV -> stall stays high until DONE; then MFLO observes the new lo.
- Assert rst_n=0 at cycle 10 of a MULT (hi/lo preloaded by a prior op) -> hi=lo=0, stall low, no done. A new MULT 5*6 then gives lo=30, hi=0.
